// File: rtl/fifo_rd_checker.sv
// Read-side checker for a FIFO carrying an incrementing data pattern.
// It locks onto the first word it reads, then compares each later word against the running expected value.
module fifo_rd_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  enable,
    input  logic                  clr,
    input  logic                  rd_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  locked,
    output logic [DATA_WIDTH-1:0] exp_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  mismatch,
    output logic                  err_flag,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t state;
    logic   rd_vld;
    logic   take;
    logic   word_bad;

    // Read handshake: a read is accepted on every rising edge where rd_en=1 (never while rd_empty=1);
    // its data is presented on rd_data for the following edge, which is flagged internally by rd_vld.
    assign rd_en     = enable & ~rd_empty & ((state == SYNC) | (state == CHECK));
    assign state_dbg = state;

    // locked is low throughout SYNC, so it alone decides whether the arriving word gets compared.
    assign take     = rd_vld & (state != IDLE);
    assign word_bad = take & locked & (rd_data != exp_data);

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state    <= IDLE;
            rd_vld   <= 1'b0;
            locked   <= 1'b0;
            exp_data <= '0;
            word_cnt <= '0;
            err_cnt  <= '0;
            mismatch <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            rd_vld   <= rd_en;
            mismatch <= word_bad;

            // After a match, rd_data+1 equals exp_data+1, so one update covers sync, match and resync.
            if (take) begin
                exp_data <= rd_data + DATA_ONE;
            end

            if (clr) begin
                word_cnt <= '0;
                err_cnt  <= '0;
                err_flag <= 1'b0;
            end else begin
                if (take && (word_cnt != CNT_MAX)) begin
                    word_cnt <= word_cnt + CNT_ONE;
                end
                if (word_bad) begin
                    err_flag <= 1'b1;
                    if (err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + CNT_ONE;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (take) begin
                        locked <= 1'b1;
                    end
                    if (!enable) begin
                        state <= DRAIN;
                    end else if (take) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!enable) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Bench for fifo_rd_checker: a queue-backed FIFO model feeds the checker, and a scoreboard holds the
// expected mismatch outcome of every issued read until the checker consumes that word.
module tb_fifo_rd_checker;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rstn;
    logic          enable;
    logic          clr;
    logic          rd_empty;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic          locked;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] err_cnt;
    logic          mismatch;
    logic          err_flag;
    logic [1:0]    state_dbg;

    fifo_rd_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rd_clk    (rd_clk),
        .rd_rstn   (rd_rstn),
        .enable    (enable),
        .clr       (clr),
        .rd_empty  (rd_empty),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .locked    (locked),
        .exp_data  (exp_data),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt),
        .mismatch  (mismatch),
        .err_flag  (err_flag),
        .state_dbg (state_dbg)
    );

    // clock/reset block
    always #5 rd_clk = ~rd_clk;

    logic [DW-1:0] src_q[$];
    logic [0:0]    exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    bit            pend        = 1'b0;
    bit            force_empty = 1'b0;
    bit            clr_on_mm   = 1'b0;
    bit            m_locked    = 1'b0;
    bit            m_flag      = 1'b0;
    logic [DW-1:0] m_exp       = '0;
    int            m_words     = 0;
    int            m_errs      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // One clock: settle inputs, predict any issued read, cross the edge, score the consumed word, then present read data.
    task automatic cycle();
        bit            issue;
        bit            proc;
        bit            mm;
        bit            mm_exp;
        logic [DW-1:0] w;
        rd_empty = force_empty || (src_q.size() == 0);
        proc     = pend;
        mm_exp   = 1'b0;
        if (proc && clr_on_mm && (exp_q.size() > 0) && exp_q[0]) clr = 1'b1;
        #1;
        issue = rd_en;
        check("rd_en_while_empty", 32'(rd_en & rd_empty), 32'd0);
        if (issue && (src_q.size() > 0)) begin
            w = src_q[0];
            if (!m_locked) begin
                m_locked = 1'b1;
                mm       = 1'b0;
            end else begin
                mm = (w != m_exp);
            end
            m_exp = w + 8'd1;
            exp_q.push_back(mm);
        end
        @(posedge rd_clk);
        #1;
        if (proc && (exp_q.size() > 0)) mm_exp = exp_q.pop_front();
        if (clr) begin
            m_words = 0;
            m_errs  = 0;
            m_flag  = 1'b0;
        end else if (proc) begin
            m_words++;
            if (mm_exp) begin
                m_errs++;
                m_flag = 1'b1;
            end
        end
        check("mismatch", 32'(mismatch), 32'(mm_exp));
        check("word_cnt", 32'(word_cnt), 32'(m_words));
        check("err_cnt", 32'(err_cnt), 32'(m_errs));
        check("err_flag", 32'(err_flag), 32'(m_flag));
        clr  = 1'b0;
        pend = issue;
        @(negedge rd_clk);
        if (pend && (src_q.size() > 0)) rd_data = src_q.pop_front();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (((src_q.size() > 0) || pend) && (n < max_cycles)) begin
            cycle();
            n++;
        end
        check("drain_done", 32'((src_q.size() > 0) || pend), 32'd0);
    endtask

    task automatic stop_run();
        enable = 1'b0;
        repeat (3) cycle();
        m_locked = 1'b0;
        check("stop_state", 32'(state_dbg), 32'd0);
        check("stop_locked", 32'(locked), 32'd0);
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        cycle();
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        src_q.push_back(a);
        src_q.push_back(b);
        src_q.push_back(c);
        src_q.push_back(d);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_exp_data"}, 32'(exp_data), 32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
        check({tag, "_err_flag"}, 32'(err_flag), 32'd0);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_rstn  = 1'b0;
        enable   = 1'b0;
        clr      = 1'b0;
        rd_empty = 1'b1;
        rd_data  = '0;
        repeat (2) @(negedge rd_clk);
        check_reset_values("reset");
        rd_rstn = 1'b1;

        // Incrementing stream 0x05..0x14
        for (int i = 5; i <= 20; i++) src_q.push_back(8'(i));
        enable = 1'b1;
        drain(100);
        check("s1_locked", 32'(locked), 32'd1);
        check("s1_word_cnt", 32'(word_cnt), 32'd16);
        check("s1_err_cnt", 32'(err_cnt), 32'd0);
        check("s1_err_flag", 32'(err_flag), 32'd0);
        check("s1_exp_data", 32'(exp_data), 32'h15);
        stop_run();
        clear_counts();

        // Wrap through all-ones
        push4(8'hFE, 8'hFF, 8'h00, 8'h01);
        enable = 1'b1;
        drain(50);
        check("s2_exp_data", 32'(exp_data), 32'h02);
        check("s2_err_cnt", 32'(err_cnt), 32'd0);
        check("s2_word_cnt", 32'(word_cnt), 32'd4);
        stop_run();
        clear_counts();

        // Single discontinuity, then resync
        push4(8'h10, 8'h11, 8'h20, 8'h21);
        enable = 1'b1;
        drain(50);
        check("s3_err_cnt", 32'(err_cnt), 32'd1);
        check("s3_err_flag", 32'(err_flag), 32'd1);
        check("s3_exp_data", 32'(exp_data), 32'h22);
        check("s3_word_cnt", 32'(word_cnt), 32'd4);
        stop_run();
        clear_counts();

        // Empty FIFO stalls in SYNC; then drop enable with one read in flight
        force_empty = 1'b1;
        enable      = 1'b1;
        repeat (5) cycle();
        check("s4_state_sync", 32'(state_dbg), 32'd1);
        check("s4_word_cnt0", 32'(word_cnt), 32'd0);
        src_q.push_back(8'h40);
        src_q.push_back(8'h41);
        force_empty = 1'b0;
        cycle();
        enable = 1'b0;
        cycle();
        check("s4_state_drain", 32'(state_dbg), 32'd3);
        check("s4_word_in_drain", 32'(word_cnt), 32'd1);
        cycle();
        m_locked = 1'b0;
        check("s4_state_idle", 32'(state_dbg), 32'd0);
        check("s4_locked", 32'(locked), 32'd0);
        src_q.delete();
        clear_counts();

        // Mismatch and clr on the same edge
        clr_on_mm = 1'b1;
        src_q.push_back(8'h30);
        src_q.push_back(8'h31);
        src_q.push_back(8'h50);
        enable = 1'b1;
        drain(50);
        clr_on_mm = 1'b0;
        check("s5_err_cnt", 32'(err_cnt), 32'd0);
        check("s5_err_flag", 32'(err_flag), 32'd0);
        check("s5_exp_data", 32'(exp_data), 32'h51);
        stop_run();
        clear_counts();

        // Reset mid-stream, then resync from scratch
        for (int i = 'h60; i <= 'h6F; i++) src_q.push_back(8'(i));
        enable = 1'b1;
        repeat (6) cycle();
        rd_rstn = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        src_q.delete();
        pend     = 1'b0;
        m_locked = 1'b0;
        m_words  = 0;
        m_errs   = 0;
        m_flag   = 1'b0;
        enable   = 1'b0;
        @(negedge rd_clk);
        rd_rstn = 1'b1;
        repeat (2) cycle();
        src_q.push_back(8'h80);
        src_q.push_back(8'h81);
        src_q.push_back(8'h82);
        enable = 1'b1;
        drain(50);
        check("s6_word_cnt", 32'(word_cnt), 32'd3);
        check("s6_err_cnt", 32'(err_cnt), 32'd0);
        check("s6_exp_data", 32'(exp_data), 32'h83);
        check("s6_locked", 32'(locked), 32'd1);
        stop_run();

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_checker.md
FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of rd_data and exp_data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of word_cnt and err_cnt.
REQ-003 SHALL have port rd_clk, input, 1 bit: the single clock; one clock, all state on rising edge.
REQ-004 SHALL have port rd_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: level; run the checker while high.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of counters and error flag.
REQ-007 SHALL have port rd_empty, input, 1 bit: FIFO read-side empty flag.
REQ-008 SHALL have port rd_data, input, DATA_WIDTH bits: FIFO read data, valid one cycle after an accepted read.
REQ-009 SHALL have port rd_en, output, 1 bit: FIFO read request.
REQ-010 SHALL have port locked, output, 1 bit: first word received, checking active.
REQ-011 SHALL have port exp_data, output, DATA_WIDTH bits: next expected value.
REQ-012 SHALL have port word_cnt, output, CNT_WIDTH bits: words received.
REQ-013 SHALL have port err_cnt, output, CNT_WIDTH bits: mismatching words.
REQ-014 SHALL have port mismatch, output, 1 bit: one-cycle pulse per mismatching word.
REQ-015 SHALL have port err_flag, output, 1 bit: sticky, any mismatch since reset or clr.

Function
REQ-016 SHALL implement states IDLE, SYNC, CHECK, DRAIN.
REQ-017 SHALL drive rd_en combinationally = enable & ~rd_empty & (state is SYNC or CHECK); rd_en SHALL never be high while rd_empty is high.
REQ-018 SHALL register rd_vld = rd_en from the previous cycle; rd_data is sampled only in cycles where rd_vld=1 (read latency 1).
REQ-019 IDLE: enable=1 -> SYNC next cycle; otherwise stay.
REQ-020 SYNC: on rd_vld, exp_data <= rd_data+1, word_cnt increments, locked <= 1, no compare, -> CHECK.
REQ-021 CHECK: on rd_vld with rd_data==exp_data: exp_data <= exp_data+1, word_cnt increments.
REQ-022 CHECK: on rd_vld with rd_data!=exp_data: mismatch=1 next cycle only, err_cnt and word_cnt increment, err_flag <= 1, exp_data <= rd_data+1 (resynchronise).
REQ-023 exp_data arithmetic SHALL be modulo 2^DATA_WIDTH: all-ones is followed by 0 without error.
REQ-024 word_cnt and err_cnt SHALL saturate at all-ones, never wrap.
REQ-025 SYNC or CHECK with enable=0 -> DRAIN; DRAIN SHALL still check the word of a read issued in the last enabled cycle, then -> IDLE; locked <= 0 on entry to IDLE.
REQ-026 Re-enabling from IDLE SHALL re-enter SYNC; the first word is not compared.
REQ-027 clr=1 SHALL zero word_cnt, err_cnt and err_flag next cycle, with priority over a same-cycle increment; state, locked and exp_data are unaffected.
REQ-028 rd_empty toggling mid-run SHALL only stall reads; no timeout, no error.

Reset
REQ-029 rd_rstn=0 SHALL immediately force state IDLE, rd_vld=0, locked=0, exp_data=0, word_cnt=0, err_cnt=0, mismatch=0, err_flag=0; rd_en=0 follows from IDLE.
REQ-030 Reset asserted mid-read SHALL discard any in-flight word; no count or compare occurs for it after release.

Verification
REQ-031 Reset, enable=1, rd_empty=0, rd_data stream 0x05,0x06,...,0x14 -> locked=1 after first word, word_cnt=16, err_cnt=0, err_flag=0, exp_data=0x15.
REQ-032 Stream 0xFE,0xFF,0x00,0x01 -> no mismatch across wrap, exp_data=0x02.
REQ-033 Stream 0x10,0x11,0x20,0x21 -> one mismatch pulse on 0x20, err_cnt=1, err_flag=1, 0x21 accepted, exp_data=0x22.
REQ-034 rd_empty=1 throughout with enable=1 -> rd_en stays 0, word_cnt=0, state SYNC; drop enable with a read in flight -> that word counted in DRAIN, then IDLE, locked=0.
REQ-035 Mismatch pending while clr=1 in the same cycle -> err_cnt=0, err_flag=0 next cycle.
REQ-036 rd_rstn pulsed low mid-stream -> all outputs at reset values immediately; after release and enable, first word re-syncs without error.
